// File: rtl/uniboard_pkg.sv
// rtl/uniboard_pkg.sv - shared Uniboard command-stream framing definitions
//
// Purpose: framing characters shared by the command-stream encoder and
// decoder, the buffered entry type, and the encoder state type.
// Ports: none (package).

package uniboard_pkg;

   localparam logic [7:0] CHAR_START  = 8'h01;
   localparam logic [7:0] CHAR_END    = 8'h17;
   localparam logic [7:0] CHAR_ESCAPE = 8'h1B;

   // One buffered request from the reply logic. is_end is never set
   // together with is_start.
   typedef struct packed {
      logic       is_start;
      logic       is_end;
      logic [7:0] data;
   } entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_LIT
   } enc_state_e;

   // Data bytes that collide with a framing character must be escaped.
   function automatic logic needs_escape(input logic [7:0] b);
      return (b == CHAR_START) || (b == CHAR_END) || (b == CHAR_ESCAPE);
   endfunction

endpackage

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - synchronous show-ahead FIFO for encoder entries
//
// Purpose: DEPTH-entry FIFO; rd_data always presents the oldest entry.
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties FIFO)
//   wr, wr_data     write request; taken if not full, or if full with a pop
//   pop             remove the oldest entry (ignored when empty)
//   rd_data         oldest entry
//   full, empty     status from pointers with one extra wrap bit

module char_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push, pull;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data = mem[rd_ptr_q[AW-1:0]];

   always_comb begin
      pull     = pop && !empty;
      // A pop in the same cycle frees a slot, so a write while full still lands.
      push     = wr && (!full || pull);
      wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = pull ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/character_encoder.sv
// rtl/character_encoder.sv - framed command-stream character encoder for UART TX
//
// Purpose: buffers data/start/end entries and emits the framed character
// stream (start 0x01, end 0x17, 0x1B before literal 0x01/0x17/0x1B), one
// character per CHAR_CLOCKS cycles.
// Optional feature macro: ENCODER_OVERFLOW_EN (sticky dropped-write flag).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   wr           write strobe for {start_c, end_c, data_in}
//   data_in      data byte (ignored for commands)
//   start_c      start command (wins over end_c)
//   end_c        end command
//   full         FIFO full
//   empty        FIFO empty and no character in flight or pending
//   data_out     character to the UART transmitter
//   send         one-cycle start pulse for the transmitter
//   overflow     sticky dropped-write flag (0 without ENCODER_OVERFLOW_EN)

module character_encoder
   import uniboard_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int CHAR_CLOCKS = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr,
   input  logic [7:0] data_in,
   input  logic       start_c,
   input  logic       end_c,
   output logic       full,
   output logic       empty,
   output logic [7:0] data_out,
   output logic       send,
   output logic       overflow
);

   localparam int CW = $clog2(CHAR_CLOCKS);
   // SEND and the following IDLE/LIT cycle make up the rest of the period,
   // so WAIT lasts CHAR_CLOCKS-2 cycles: counts CHAR_CLOCKS-3 down to 0.
   localparam logic [CW-1:0] CNT_LOAD = CW'(CHAR_CLOCKS - 3);

   entry_t     wr_entry, rd_entry;
   logic       fifo_full, fifo_empty, fifo_pop;

   enc_state_e state_q, state_d;
   logic [7:0] dout_q, dout_d;
   logic       send_q, send_d;
   logic       pend_q, pend_d;
   logic [7:0] pend_byte_q, pend_byte_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      wr_entry.is_start = start_c;
      wr_entry.is_end   = end_c & ~start_c;
      wr_entry.data     = data_in;
   end

   char_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr),
      .wr_data (wr_entry),
      .pop     (fifo_pop),
      .rd_data (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      dout_d      = dout_q;
      send_d      = 1'b0;
      pend_d      = pend_q;
      pend_byte_d = pend_byte_q;
      cnt_d       = cnt_q;
      fifo_pop    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = ST_SEND;
               if (rd_entry.is_start) begin
                  dout_d = CHAR_START;
               end else if (rd_entry.is_end) begin
                  dout_d = CHAR_END;
               end else if (needs_escape(rd_entry.data)) begin
                  dout_d      = CHAR_ESCAPE;
                  pend_d      = 1'b1;
                  pend_byte_d = rd_entry.data;
               end else begin
                  dout_d = rd_entry.data;
               end
            end
         end
         ST_SEND: begin
            send_d  = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = pend_q ? ST_LIT : ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_LIT: begin
            dout_d  = pend_byte_q;
            pend_d  = 1'b0;
            state_d = ST_SEND;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         dout_q      <= 8'h00;
         send_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_byte_q <= 8'h00;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         dout_q      <= dout_d;
         send_q      <= send_d;
         pend_q      <= pend_d;
         pend_byte_q <= pend_byte_d;
         cnt_q       <= cnt_d;
      end
   end

   assign data_out = dout_q;
   assign send     = send_q;
   assign full     = fifo_full;
   assign empty    = fifo_empty && (state_q == ST_IDLE) && !pend_q;

`ifdef ENCODER_OVERFLOW_EN
   logic overflow_q, overflow_d;

   // A write is dropped only when full and no pop frees a slot that cycle.
   always_comb begin
      overflow_d = overflow_q | (wr & fifo_full & ~fifo_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: doc/character_encoder.md
# character_encoder

Transmit-side counterpart of the Uniboard command-stream decoder. It accepts data bytes, start commands and end commands from the reply logic and buffers them in a small FIFO. It turns each entry into the framed character stream (start 0x01, end 0x17, escape 0x1B before any literal 0x01/0x17/0x1B) and paces those characters into the UART transmitter at one character per character-time. It sits between the command/reply engine and the UART transmitter on clk_12MHz.

## Interface
- FIFO_DEPTH, 16: entries buffered; power of two, ≥2.
- CHAR_CLOCKS, 120: clk cycles between successive send pulses (10 bits × 12 clk/bit); ≥4.
- clk  in  1  system clock (clk_12MHz).
- reset  in  1  **synchronous, active-high; one clock, reset sampled on posedge clk.**
- wr  in  1  one-cycle write strobe; entry captured on the clk edge where wr=1 and full=0.
- data_in  in  8  byte to send; ignored when start_c or end_c is high.
- start_c  in  1  entry is a start command.
- end_c  in  1  entry is an end command.
- full  out  1  FIFO full; a write while full is dropped.
- empty  out  1  FIFO empty and encoder idle (no character in flight or pending).
- data_out  out  8  character to UART transmitter.
- send  out  1  one-cycle pulse; transmitter starts the character on data_out.
- overflow  out  1  sticky dropped-write flag (see Configuration).

## Operation
- Entry = {start_c, end_c, data_in}. If start_c and end_c are both high, the entry is a start command.
- Encoding per popped entry:
  - start → 0x01.
  - end → 0x17.
  - data in {0x01, 0x17, 0x1B} → 0x1B, then the byte.
  - other data → the byte.
- FSM states:
  - IDLE: if FIFO non-empty, pop. Load data_out with the first character. If an escape is needed, latch the literal byte into the pending register. Go to SEND.
  - SEND: send=1 for this cycle only. Load the pace counter. Go to WAIT.
  - WAIT: count down. At terminal count: if a pending literal exists, go to LIT; else go to IDLE.
  - LIT: data_out ← pending byte, clear pending, go to SEND.
- data_out changes only in IDLE→SEND or LIT→SEND. It is stable for ≥1 cycle before send and until the next load.
- Simultaneous wr and pop are allowed in the same cycle, including when full (the pop frees a slot first, then the write is accepted) and when empty-with-wr (the write lands; the pop occurs next cycle).
- FIFO pointers wrap modulo FIFO_DEPTH. full/empty are derived from an extra pointer bit.

## Timing
- Reset values: data_out=0x00, send=0, full=0, empty=1, overflow=0. FIFO is emptied, pending cleared, counter=0, state IDLE.
- Reset mid-character aborts immediately. The in-flight escape pair is lost, and no send is issued in the cycle after reset.
- Latency: wr on edge k into an empty, idle encoder → send high in the cycle after edge k+2.
- Back-to-back characters, including escape→literal and the next entry: send pulses exactly CHAR_CLOCKS cycles apart.
- empty deasserts on the edge that writes and reasserts on the edge WAIT finishes with FIFO empty and no pending literal.

## Configuration
- ENCODER_OVERFLOW_EN defined: overflow sets on any edge with wr=1 and an effective full (full with no simultaneous pop). It stays set until reset.
- ENCODER_OVERFLOW_EN undefined: the overflow port remains and is tied to 0. No flag logic is synthesised.

## Structure
- Shared package uniboard_pkg holds:
  - constants CHAR_START=8'h01, CHAR_END=8'h17, CHAR_ESCAPE=8'h1B, shared with the decoder;
  - the entry struct typedef {start, end, data[7:0]};
  - the FSM state enum.
- One sub-module, char_fifo: parameterised synchronous FIFO with write, pop, full and empty, instantiated once.

## Test plan
- Reset, then write data 0x41 with CHAR_CLOCKS=120 → one send pulse 2 cycles after wr, data_out=0x41; empty returns to 1 after 120 cycles.
- Write start, 0x55, end back-to-back → data_out sequence 0x01, 0x55, 0x17; send pulses 120 cycles apart.
- Write data 0x01, 0x17, 0x1B, 0x18 → 0x1B 0x01 0x1B 0x17 0x1B 0x1B 0x18 (7 sends, uniform spacing).
- Write 20 entries, FIFO_DEPTH=16, while the first is in flight → full asserts. Extra writes are dropped; overflow=1 with ENCODER_OVERFLOW_EN and 0 without. The stored 16 entries are transmitted in order.
- Assert reset in WAIT between 0x1B and its literal → next cycles show send=0, data_out=0x00, empty=1. A fresh write of 0x42 then transmits normally.
- Hold wr with start_c=end_c=1 for one cycle → single 0x01 sent.
